// File: rtl/max_pool_layer.sv
`default_nettype none
// ============================================================================
// Module   : max_pool_layer
// Purpose  : Streaming 2x2 / stride-2 signed max-pool with valid/ready flow.
// Revision : 1.0
// ============================================================================
module max_pool_layer #(
    parameter int DATA_WIDTH = 45,
    parameter int IN_X       = 24,
    parameter int IN_Y       = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pool_enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  pool_done
);

    localparam int c_COL_W  = (IN_X > 2) ? $clog2(IN_X) : 1;
    localparam int c_ROW_W  = (IN_Y > 2) ? $clog2(IN_Y) : 1;
    localparam int c_HALF_X = IN_X / 2;
    localparam int c_IDX_W  = (c_HALF_X > 1) ? $clog2(c_HALF_X) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_COL_W-1:0]    r_col;
    logic [c_ROW_W-1:0]    r_row;
    logic [DATA_WIDTH-1:0] r_h;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_pool_done;
    logic [DATA_WIDTH-1:0] r_line_buf [c_HALF_X];

    logic                  w_accept;
    logic                  w_emit;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_load;
    logic [c_IDX_W-1:0]    w_idx;
    logic [DATA_WIDTH-1:0] w_hmax;
    logic [DATA_WIDTH-1:0] w_lb;
    logic [DATA_WIDTH-1:0] w_vmax;

    assign in_ready   = (r_state == S_RUN) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_emit     = r_out_valid && out_ready;
    assign w_col_last = (r_col == c_COL_W'(IN_X - 1));
    assign w_row_last = (r_row == c_ROW_W'(IN_Y - 1));
    assign w_load     = w_accept && r_col[0] && r_row[0];
    assign w_idx      = c_IDX_W'(r_col >> 1);

    assign w_hmax = ($signed(r_h) > $signed(in_data)) ? r_h : in_data;
    assign w_lb   = r_line_buf[w_idx];
    assign w_vmax = ($signed(w_lb) > $signed(w_hmax)) ? w_lb : w_hmax;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign pool_done = r_pool_done;

    // Top-row horizontal maxima wait here for their bottom-row partners.
    always_ff @(posedge clk) begin
        if (w_accept && r_col[0] && !r_row[0]) begin
            r_line_buf[w_idx] <= w_hmax;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_h         <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_pool_done <= 1'b0;
        end else begin
            r_pool_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_col <= '0;
                    r_row <= '0;
                    if (pool_enable) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (!pool_enable) begin
                        r_state     <= S_IDLE;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_h         <= '0;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end else begin
                        if (w_accept) begin
                            if (w_col_last) begin
                                r_col <= '0;
                                r_row <= w_row_last ? '0 : r_row + c_ROW_W'(1);
                            end else begin
                                r_col <= r_col + c_COL_W'(1);
                            end
                            if (!r_col[0]) begin
                                r_h <= in_data;
                            end
                        end
                        // A fresh load wins over an emit in the same cycle.
                        if (w_load) begin
                            r_out_data  <= w_vmax;
                            r_out_valid <= 1'b1;
                            r_out_last  <= w_col_last && w_row_last;
                        end else if (w_emit) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                        if (r_state == S_RUN && w_accept && w_col_last && w_row_last) begin
                            r_state <= S_DRAIN;
                        end
                        if (r_state == S_DRAIN && w_emit && r_out_last) begin
                            r_state     <= S_DONE;
                            r_pool_done <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_max_pool_layer.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_pool_layer
// Purpose  : Directed self-checking bench for max_pool_layer (4x4 and 24x24).
// Revision : 1.0
// ============================================================================
module tb_max_pool_layer;

    localparam int DW = 45;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          a_en = 1'b0, a_iv = 1'b0, a_or = 1'b0;
    logic [DW-1:0] a_id = '0;
    logic          a_ir, a_ov, a_ol, a_done;
    logic [DW-1:0] a_od;

    logic          b_en = 1'b0, b_iv = 1'b0, b_or = 1'b0;
    logic [DW-1:0] b_id = '0;
    logic          b_ir, b_ov, b_ol, b_done;
    logic [DW-1:0] b_od;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0]        a_pix [32];
    logic [DW-1:0]        a_out_q [$];
    bit                   a_last_q [$];
    int                   a_done_cnt;
    int                   a_done_cyc;
    int                   a_last_emit_cyc;

    logic signed [DW-1:0] b_pix [576];
    logic signed [DW-1:0] b_exp [144];

    max_pool_layer #(.DATA_WIDTH(DW), .IN_X(4), .IN_Y(4)) u_dut_a (
        .clk(clk), .rst(rst_n), .pool_enable(a_en),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .out_last(a_ol), .pool_done(a_done)
    );

    max_pool_layer u_dut_b (
        .clk(clk), .rst(rst_n), .pool_enable(b_en),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .out_last(b_ol), .pool_done(b_done)
    );

    always #5 clk = ~clk;

    // Streams n_pix pixels into the 4x4 instance with out_ready high and
    // records every emit until n_done pool_done pulses have been seen.
    task automatic run_a(input int n_pix, input int n_done);
        int idx = 0;
        int cyc = 0;
        a_out_q.delete();
        a_last_q.delete();
        a_done_cnt      = 0;
        a_done_cyc      = -1;
        a_last_emit_cyc = -100;
        a_en = 1'b1;
        while (a_done_cnt < n_done && cyc < 400) begin
            @(negedge clk);
            a_iv = (idx < n_pix);
            a_id = (idx < n_pix) ? a_pix[idx] : '0;
            a_or = 1'b1;
            #1;
            if (a_done) begin
                a_done_cnt++;
                a_done_cyc = cyc;
            end
            if (a_ov && a_or) begin
                a_out_q.push_back(a_od);
                a_last_q.push_back(a_ol);
                if (a_ol) a_last_emit_cyc = cyc;
            end
            if (a_iv && a_ir) idx++;
            cyc++;
        end
        a_en = 1'b0;
        a_iv = 1'b0;
        if (cyc >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_a_timeout: got %0d done pulses, required %0d", a_done_cnt, n_done);
        end
        @(negedge clk);
    endtask

    task automatic feed_a_partial(input int n_acc);
        int idx = 0;
        int cyc = 0;
        a_en = 1'b1;
        while (idx < n_acc && cyc < 100) begin
            @(negedge clk);
            a_iv = 1'b1;
            a_id = a_pix[idx];
            #1;
            if (a_ir) idx++;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_en  = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({a_ir, a_ov, a_ol, a_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_a_flags: got %b required 0000", {a_ir, a_ov, a_ol, a_done});
        end
        n_checks++;
        if (a_od !== '0) begin
            n_fail++;
            $display("FAIL reset_a_data: got %h required 0", a_od);
        end
        n_checks++;
        if ({b_ir, b_ov, b_ol, b_done} !== 4'b0000 || b_od !== '0) begin
            n_fail++;
            $display("FAIL reset_b_outputs: got %b/%h required 0000/0", {b_ir, b_ov, b_ol, b_done}, b_od);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a_en  = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (a_ir !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_in_ready: got %b required 0", a_ir);
        end
    endtask

    task automatic test_basic();
        int exp_v [4];
        logic [DW-1:0] got;
        bit got_l;
        exp_v = '{5, 7, 13, 15};
        for (int i = 0; i < 16; i++) a_pix[i] = DW'(i);
        run_a(16, 1);
        n_checks++;
        if (a_out_q.size() != 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d required 4", a_out_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got   = (i < a_out_q.size()) ? a_out_q[i] : 'x;
            got_l = (i < a_last_q.size()) ? a_last_q[i] : 1'b0;
            n_checks++;
            if (got !== DW'(exp_v[i]) || got_l !== (i == 3)) begin
                n_fail++;
                $display("FAIL basic_out[%0d]: got %0d last=%b required %0d last=%b",
                         i, $signed(got), got_l, exp_v[i], (i == 3));
            end
        end
        n_checks++;
        if (a_done_cnt != 1 || a_done_cyc != a_last_emit_cyc + 1) begin
            n_fail++;
            $display("FAIL basic_done: got %0d pulses at cycle %0d required 1 at cycle %0d",
                     a_done_cnt, a_done_cyc, a_last_emit_cyc + 1);
        end
    endtask

    task automatic test_signed();
        int exp_v [4];
        logic [DW-1:0] got;
        exp_v = '{-1, -1, -1, 3};
        for (int i = 0; i < 16; i++) a_pix[i] = '1;
        a_pix[1]  = DW'(-7);
        a_pix[14] = DW'(3);
        run_a(16, 1);
        n_checks++;
        if (a_out_q.size() != 4) begin
            n_fail++;
            $display("FAIL signed_count: got %0d required 4", a_out_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < a_out_q.size()) ? a_out_q[i] : 'x;
            n_checks++;
            if (got !== DW'(exp_v[i])) begin
                n_fail++;
                $display("FAIL signed_out[%0d]: got %0d required %0d", i, $signed(got), exp_v[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0]          t;
        logic signed [DW-1:0] m;
        logic [DW-1:0]        held_data;
        bit                   held;
        bit                   done_seen;
        int                   idx, n_out, cyc, p;
        for (int i = 0; i < 576; i++) begin
            t = {$urandom(), $urandom()};
            b_pix[i] = t[DW-1:0];
        end
        for (int oy = 0; oy < 12; oy++) begin
            for (int ox = 0; ox < 12; ox++) begin
                p = (2 * oy) * 24 + 2 * ox;
                m = b_pix[p];
                if (b_pix[p + 1] > m)  m = b_pix[p + 1];
                if (b_pix[p + 24] > m) m = b_pix[p + 24];
                if (b_pix[p + 25] > m) m = b_pix[p + 25];
                b_exp[oy * 12 + ox] = m;
            end
        end
        idx = 0; n_out = 0; cyc = 0; held = 1'b0; held_data = '0; done_seen = 1'b0;
        b_en = 1'b1;
        while (!done_seen && cyc < 6000) begin
            @(negedge clk);
            b_iv = (idx < 576);
            b_id = (idx < 576) ? b_pix[idx] : '0;
            b_or = ($urandom_range(0, 2) != 0);
            #1;
            if (held) begin
                n_checks++;
                if (b_ov !== 1'b1 || b_od !== held_data) begin
                    n_fail++;
                    $display("FAIL bp_stable: got valid=%b data=%h required valid=1 data=%h", b_ov, b_od, held_data);
                end
            end
            if (b_ov && !b_or) begin
                n_checks++;
                if (b_ir !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_in_ready: got %b required 0 while output held", b_ir);
                end
                held      = 1'b1;
                held_data = b_od;
            end else begin
                held = 1'b0;
            end
            if (b_ov && b_or) begin
                n_checks++;
                if (n_out >= 144 || b_od !== b_exp[n_out] || b_ol !== (n_out == 143)) begin
                    n_fail++;
                    $display("FAIL bp_out[%0d]: got %h last=%b required %h last=%b", n_out, b_od, b_ol,
                             (n_out < 144) ? b_exp[n_out] : '0, (n_out == 143));
                end
                n_out++;
            end
            if (b_iv && b_ir) idx++;
            if (b_done) done_seen = 1'b1;
            cyc++;
        end
        b_en = 1'b0;
        b_iv = 1'b0;
        n_checks++;
        if (n_out != 144 || !done_seen) begin
            n_fail++;
            $display("FAIL bp_total: got %0d outputs done=%b required 144 done=1", n_out, done_seen);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int exp_v [4];
        int done_seen;
        logic [DW-1:0] got;
        exp_v = '{5, 7, 13, 15};
        for (int i = 0; i < 16; i++) a_pix[i] = DW'(i);
        a_or = 1'b1;
        feed_a_partial(9);
        @(negedge clk);
        a_en = 1'b0;
        a_iv = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (a_done) done_seen++;
            if (k == 0) begin
                n_checks++;
                if (a_ir !== 1'b0 || a_ov !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_idle: got in_ready=%b out_valid=%b required 0/0", a_ir, a_ov);
                end
            end
        end
        n_checks++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d pulses required 0", done_seen);
        end
        // Abort while a pooled value is parked in the output register.
        a_or = 1'b0;
        feed_a_partial(6);
        @(negedge clk);
        #1;
        n_checks++;
        if (a_ov !== 1'b1 || a_od !== DW'(5)) begin
            n_fail++;
            $display("FAIL abort_held: got valid=%b data=%0d required valid=1 data=5", a_ov, a_od);
        end
        a_en = 1'b0;
        a_iv = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (a_ov !== 1'b0 || a_ol !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_clear: got valid=%b last=%b required 0/0", a_ov, a_ol);
        end
        a_or = 1'b1;
        run_a(16, 1);
        for (int i = 0; i < 4; i++) begin
            got = (i < a_out_q.size()) ? a_out_q[i] : 'x;
            n_checks++;
            if (got !== DW'(exp_v[i])) begin
                n_fail++;
                $display("FAIL abort_reframe[%0d]: got %0d required %0d", i, $signed(got), exp_v[i]);
            end
        end
        n_checks++;
        if (a_out_q.size() != 4 || a_done_cnt != 1) begin
            n_fail++;
            $display("FAIL abort_reframe_count: got %0d outputs %0d done required 4/1", a_out_q.size(), a_done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int exp_v [4];
        logic [DW-1:0] got;
        exp_v = '{5, 7, 13, 15};
        for (int i = 0; i < 16; i++) a_pix[i] = DW'(i);
        a_or = 1'b0;
        feed_a_partial(6);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_ir, a_ov, a_ol, a_done} !== 4'b0000 || a_od !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got flags=%b data=%h required 0000/0", {a_ir, a_ov, a_ol, a_done}, a_od);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a_en  = 1'b0;
        a_iv  = 1'b0;
        a_or  = 1'b1;
        @(negedge clk);
        run_a(16, 1);
        for (int i = 0; i < 4; i++) begin
            got = (i < a_out_q.size()) ? a_out_q[i] : 'x;
            n_checks++;
            if (got !== DW'(exp_v[i])) begin
                n_fail++;
                $display("FAIL reset_mid_frame[%0d]: got %0d required %0d", i, $signed(got), exp_v[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_v [8];
        logic [DW-1:0] got;
        bit got_l;
        exp_v = '{5, 7, 13, 15, 15, 13, 7, 5};
        for (int i = 0; i < 16; i++) begin
            a_pix[i]      = DW'(i);
            a_pix[16 + i] = DW'(15 - i);
        end
        run_a(32, 2);
        n_checks++;
        if (a_out_q.size() != 8 || a_done_cnt != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs %0d done required 8/2", a_out_q.size(), a_done_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            got   = (i < a_out_q.size()) ? a_out_q[i] : 'x;
            got_l = (i < a_last_q.size()) ? a_last_q[i] : 1'b0;
            n_checks++;
            if (got !== DW'(exp_v[i]) || got_l !== (i == 3 || i == 7)) begin
                n_fail++;
                $display("FAIL b2b_out[%0d]: got %0d last=%b required %0d last=%b",
                         i, $signed(got), got_l, exp_v[i], (i == 3 || i == 7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
